// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-write sequencer:
// FSM state encoding, frame geometry, table-entry packing and the
// WM8731 codec power-up register set used as the default table.
package i2c_seq_pkg;

  // Sequencer states, in the order a normal write walks through them.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4,
    DONE = 3'd5,
    FAIL = 3'd6
  } seq_state_t;

  // Full frame handed to the byte-level master: {devAddr, regAddr, regData}.
  localparam int FRAME_W = 24;

  // One table entry: {regAddr[6:0], regData[8:0]}.
  localparam int ENTRY_W = 16;

  // Builds one 16-bit table entry from a 7-bit register address and 9-bit data.
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [6:0] regAddr,
                                                    input logic [8:0] regData);
    return {regAddr, regData};
  endfunction

  // WM8731 bring-up sequence; entry 0 sits in the least significant 16 bits.
  localparam logic [6*ENTRY_W-1:0] WM8731_DEFAULT_TABLE = {
    pack_entry(7'h01, 9'h017),
    pack_entry(7'h00, 9'h017),
    pack_entry(7'h06, 9'h039),
    pack_entry(7'h09, 9'h001),
    pack_entry(7'h07, 9'h042),
    pack_entry(7'h04, 9'h004)
  };

endpackage

// File: rtl/i2c_reg_sequencer.sv
// Table-driven I2C register-write sequencer. Walks INIT_TABLE, presents each
// 24-bit frame to the byte-level master, retries NACKed writes up to
// MAX_RETRY attempts, idles GAP_CYCLES cycles after every transaction and
// reports completion (ready) or an exhausted entry (error/failIndex).
//
// Handshake with the master: txReq is a one-cycle launch pulse while txData
// is already stable (it was loaded the cycle before and holds until the next
// LOAD). The master answers with a one-cycle txDone pulse, carrying txAck in
// the same cycle; txDone is only honoured in WAIT, which is entered the cycle
// after txReq, so a txDone on the very next cycle is accepted.
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int                          NUM_REGS   = 6,
  parameter logic [7:0]                  DEV_ADDR   = 8'h35,
  parameter logic [NUM_REGS*ENTRY_W-1:0] INIT_TABLE = WM8731_DEFAULT_TABLE,
  parameter int                          MAX_RETRY  = 3,
  parameter int                          GAP_CYCLES = 16,
  parameter bit                          AUTO_START = 1'b1,
  localparam int                         IDX_W      = $clog2(NUM_REGS + 1),
  localparam int                         FAIL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int                         ACK_W      = $clog2(NUM_REGS + 1)
) (
  input  logic               inClock,
  input  logic               reset,
  input  logic               start,
  output logic [FRAME_W-1:0] txData,
  output logic               txReq,
  input  logic               txDone,
  input  logic               txAck,
  output logic               busy,
  output logic               ready,
  output logic               error,
  output logic [FAIL_W-1:0]  failIndex,
  output logic [ACK_W-1:0]   ackNum,
  output seq_state_t         stateDbg
);

  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  // The index is wide enough to hold NUM_REGS itself, so the end-of-table
  // compare after the increment never wraps, even for power-of-2 tables.
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ACK_W-1:0] ACK_MAX   = ACK_W'(NUM_REGS);

  seq_state_t         state, stateNext;
  logic [IDX_W-1:0]   idx, idxNext;
  logic [RTY_W-1:0]   retryCnt, retryNext, retryInc;
  logic [GAP_W-1:0]   gapCnt, gapNext;
  logic               armed, armedNext;
  logic [FRAME_W-1:0] txDataNext;
  logic               busyNext, readyNext, errorNext;
  logic [FAIL_W-1:0]  failNext;
  logic [ACK_W-1:0]   ackNext;
  logic               launch;

  // Selects table entry idx; indices outside the table read as zero.
  function automatic logic [ENTRY_W-1:0] table_entry(input logic [IDX_W-1:0] sel);
    logic [ENTRY_W-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == IDX_W'(i)) e = INIT_TABLE[ENTRY_W*i +: ENTRY_W];
    end
    return e;
  endfunction

  // Next-state and next-register values for the whole sequencer.
  always_comb begin
    stateNext  = state;
    idxNext    = idx;
    retryNext  = retryCnt;
    gapNext    = gapCnt;
    armedNext  = armed;
    txDataNext = txData;
    busyNext   = busy;
    readyNext  = ready;
    errorNext  = error;
    failNext   = failIndex;
    ackNext    = ackNum;
    retryInc   = retryCnt + 1'b1;
    launch     = 1'b0;

    case (state)
      IDLE: launch = start || (AUTO_START && armed);
      LOAD: begin
        txDataNext = {DEV_ADDR, table_entry(idx)};
        stateNext  = REQ;
      end
      REQ:  stateNext = WAIT;
      WAIT: begin
        if (txDone) begin
          if (txAck) begin
            if (ackNum != ACK_MAX) ackNext = ackNum + 1'b1;
            idxNext   = idx + 1'b1;
            retryNext = '0;
            stateNext = GAP;
          end else begin
            retryNext = retryInc;
            if (retryInc == RTY_LIMIT) begin
              stateNext = FAIL;
              errorNext = 1'b1;
              busyNext  = 1'b0;
              failNext  = idx[FAIL_W-1:0];
            end else begin
              stateNext = GAP;
            end
          end
        end
      end
      GAP: begin
        if (gapCnt == GAP_LAST) begin
          gapNext = '0;
          if (idx == LAST_IDX) begin
            stateNext = DONE;
            readyNext = 1'b1;
            busyNext  = 1'b0;
          end else begin
            stateNext = LOAD;
          end
        end else begin
          gapNext = gapCnt + 1'b1;
        end
      end
      DONE:    launch = start;
      FAIL:    launch = start;
      default: stateNext = IDLE;
    endcase

    // A (re)launch restarts the table from entry 0 with fresh status.
    if (launch) begin
      stateNext = LOAD;
      idxNext   = '0;
      retryNext = '0;
      gapNext   = '0;
      armedNext = 1'b0;
      ackNext   = '0;
      readyNext = 1'b0;
      errorNext = 1'b0;
      failNext  = '0;
      busyNext  = 1'b1;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge inClock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      retryCnt  <= '0;
      gapCnt    <= '0;
      armed     <= 1'b1;
      txData    <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      error     <= 1'b0;
      failIndex <= '0;
      ackNum    <= '0;
    end else begin
      state     <= stateNext;
      idx       <= idxNext;
      retryCnt  <= retryNext;
      gapCnt    <= gapNext;
      armed     <= armedNext;
      txData    <= txDataNext;
      busy      <= busyNext;
      ready     <= readyNext;
      error     <= errorNext;
      failIndex <= failNext;
      ackNum    <= ackNext;
    end
  end

  // Launch pulse; gated by reset so it drops as soon as reset is raised.
  assign txReq = (state == REQ) && !reset;

  assign stateDbg = state;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Randomised bench for i2c_reg_sequencer: a reference model expands a
// per-entry NACK plan into the expected frame stream and final status, a
// responder plays the I2C master, and a monitor checks each txReq against
// the expected queue. A second small instance covers the 1-entry corner.
module tb_i2c_reg_sequencer;
  import i2c_seq_pkg::*;

  localparam int NREG = 6;
  localparam int MR   = 3;
  localparam int G    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset = 1'b1;
  logic start_drv = 1'b0, start_noise = 1'b0;
  logic done_drv = 1'b0, done_noise = 1'b0, ack_drv = 1'b0;
  logic start, txDone, txAck;
  assign start  = start_drv | start_noise;
  assign txDone = done_drv | done_noise;
  assign txAck  = ack_drv;

  logic [23:0] txData;
  logic        txReq, busy, ready, error;
  logic [2:0]  failIndex, ackNum;
  seq_state_t  stateDbg;

  i2c_reg_sequencer u_dut (
    .inClock(clk), .reset(reset), .start(start), .txData(txData), .txReq(txReq),
    .txDone(txDone), .txAck(txAck), .busy(busy), .ready(ready), .error(error),
    .failIndex(failIndex), .ackNum(ackNum), .stateDbg(stateDbg)
  );

  // Small configuration: one entry, one attempt, one gap cycle.
  logic        s_reset = 1'b1, s_start = 1'b0, s_done = 1'b0, s_ack = 1'b0;
  logic [23:0] s_txData;
  logic        s_txReq, s_busy, s_ready, s_error;
  logic [0:0]  s_failIndex, s_ackNum;
  seq_state_t  s_state;
  localparam logic [23:0] S_FRAME = {8'h34, 7'h0F, 9'h000};

  i2c_reg_sequencer #(
    .NUM_REGS(1), .DEV_ADDR(8'h34), .INIT_TABLE({7'h0F, 9'h000}),
    .MAX_RETRY(1), .GAP_CYCLES(1), .AUTO_START(1'b1)
  ) u_small (
    .inClock(clk), .reset(s_reset), .start(s_start), .txData(s_txData), .txReq(s_txReq),
    .txDone(s_done), .txAck(s_ack), .busy(s_busy), .ready(s_ready), .error(s_error),
    .failIndex(s_failIndex), .ackNum(s_ackNum), .stateDbg(s_state)
  );

  // ---------------- reference model ----------------
  logic [6:0] ref_addr [NREG] = '{7'h04, 7'h07, 7'h09, 7'h06, 7'h00, 7'h01};
  logic [8:0] ref_data [NREG] = '{9'h004, 9'h042, 9'h001, 9'h039, 9'h017, 9'h017};

  function automatic logic [23:0] frame_of(input int i);
    return {8'h35, ref_addr[i], ref_data[i]};
  endfunction

  int          nack_plan [NREG];
  logic [23:0] exp_q [$];
  bit          ack_q [$];
  int          m_acked, m_fidx;
  bit          m_failed;

  // Expands the NACK plan: each entry gets up to MR attempts; it is acked on
  // the attempt after its planned NACKs, or the run fails at that entry.
  task automatic build_plan();
    exp_q.delete();
    ack_q.delete();
    m_acked = 0; m_failed = 0; m_fidx = 0;
    for (int i = 0; i < NREG && !m_failed; i++) begin
      for (int a = 0; a < MR; a++) begin
        exp_q.push_back(frame_of(i));
        if (a < nack_plan[i]) begin
          ack_q.push_back(1'b0);
          if (a == MR - 1) begin m_failed = 1; m_fidx = i; end
        end else begin
          ack_q.push_back(1'b1);
          m_acked++;
          break;
        end
      end
    end
  endtask

  task automatic rand_plan();
    for (int i = 0; i < NREG; i++) begin
      int r;
      r = $urandom_range(0, 19);
      nack_plan[i] = (r < 13) ? 0 : (r < 17) ? 1 : (r < 19) ? 2 : 3;
    end
  endtask

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0, n_err = 0;
  int kick_req_cyc = 0, done_req_cyc = 0, last_done_cyc = 0, rdy_cyc = 0, err_cyc = 0;
  bit noise_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- master responder ----------------
  initial begin
    bit a, aborted;
    int d;
    forever begin
      @(negedge clk);
      done_drv = 1'b0;
      ack_drv  = 1'($urandom_range(0, 1));
      if (!reset && txReq) begin
        a = 1'b1;
        if (ack_q.size() != 0) a = ack_q.pop_front();
        d = $urandom_range(0, 3);
        aborted = 0;
        for (int k = 0; k <= d; k++) begin
          @(negedge clk);
          if (reset) aborted = 1;
        end
        if (!aborted) begin
          done_drv      = 1'b1;
          ack_drv       = a;
          last_done_cyc = cyc;
          done_req_cyc  = cyc + G + 2;
        end
      end
    end
  end

  // ---------------- spurious start/txDone in GAP and LOAD ----------------
  initial begin
    forever begin
      @(negedge clk);
      start_noise = 1'b0;
      done_noise  = 1'b0;
      if (noise_en && !reset && (stateDbg == GAP || stateDbg == LOAD) &&
          $urandom_range(0, 3) == 0) begin
        start_noise = 1'b1;
        done_noise  = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [23:0] e;
    logic ready_q, error_q;
    ready_q = 1'b0; error_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (txReq) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_req: txData %0h at cycle %0d, no frame expected", txData, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("frame", 32'(txData), 32'(e));
          end
          chk("req_cycle", cyc, (kick_req_cyc > done_req_cyc) ? kick_req_cyc : done_req_cyc);
          chk("busy_in_req", 32'(busy), 1);
        end
        if (ready && !ready_q) rdy_cyc = cyc;
        if (error && !error_q) err_cyc = cyc;
      end
      ready_q = ready;
      error_q = error;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_seq(input bit by_start, input bit noise);
    int s;
    build_plan();
    if (by_start) begin
      start_drv = 1'b1;
      kick_req_cyc = cyc + 2;
      @(negedge clk);
      start_drv = 1'b0;
    end else begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      kick_req_cyc = cyc + 2;
      @(negedge clk);
    end
    chk("launch_busy", 32'(busy), 1);
    chk("launch_acknum", 32'(ackNum), 0);
    chk("launch_ready", 32'(ready), 0);
    chk("launch_error", 32'(error), 0);
    noise_en = noise;
    for (s = 0; s < 3000; s++) begin
      if (ready || error) break;
      @(negedge clk);
    end
    chk("run_finished", 32'(ready | error), 1);
    noise_en = 0;
    repeat (G + 8) @(negedge clk);
    chk("final_ready", 32'(ready), m_failed ? 0 : 1);
    chk("final_error", 32'(error), m_failed ? 1 : 0);
    chk("final_acknum", 32'(ackNum), m_acked);
    chk("final_failidx", 32'(failIndex), m_failed ? m_fidx : 0);
    chk("final_busy", 32'(busy), 0);
    chk("frames_left", exp_q.size(), 0);
    if (m_failed) chk("error_latency", err_cyc - last_done_cyc, 1);
    else          chk("ready_latency", rdy_cyc - last_done_cyc, G + 1);
  endtask

  task automatic reset_mid();
    int k, n;
    for (int i = 0; i < NREG; i++) nack_plan[i] = 0;
    build_plan();
    start_drv = 1'b1;
    kick_req_cyc = cyc + 2;
    @(negedge clk);
    start_drv = 1'b0;
    k = $urandom_range(1, 3);
    n = 0;
    for (int s = 0; s < 2000 && n < k; s++) begin
      @(negedge clk);
      if (txReq) n++;
    end
    chk("midrun_reqs", n, k);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_txdata", 32'(txData), 0);
    chk("rst_txreq", 32'(txReq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_failidx", 32'(failIndex), 0);
    chk("rst_acknum", 32'(ackNum), 0);
    repeat (30) @(negedge clk);
    exp_q.delete();
    ack_q.delete();
    for (int i = 0; i < NREG; i++) nack_plan[i] = 0;
    run_seq(1'b0, 1'b1);
  endtask

  task automatic small_test();
    int rel, d, n;
    bit found;
    s_reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("s_rst_txdata", 32'(s_txData), 0);
    chk("s_rst_busy", 32'(s_busy), 0);
    chk("s_rst_acknum", 32'(s_ackNum), 0);
    s_reset = 1'b0;
    rel = cyc;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (s_txReq) found = 1;
    end
    chk("s_auto_req_seen", 32'(found), 1);
    chk("s_auto_req_cycle", cyc, rel + 2);
    chk("s_frame", 32'(s_txData), 32'(S_FRAME));
    @(negedge clk);
    s_done = 1'b1; s_ack = 1'b0;
    @(negedge clk);
    s_done = 1'b0; s_ack = 1'b1;
    chk("s_nack_error", 32'(s_error), 1);
    chk("s_nack_failidx", 32'(s_failIndex), 0);
    chk("s_nack_acknum", 32'(s_ackNum), 0);
    chk("s_nack_ready", 32'(s_ready), 0);
    chk("s_nack_busy", 32'(s_busy), 0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (s_txReq) n++;
    end
    chk("s_no_retry", n, 0);
    s_start = 1'b1;
    rel = cyc;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_launch_error", 32'(s_error), 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (s_txReq) found = 1;
    end
    chk("s_start_req_cycle", cyc, rel + 2);
    chk("s_frame2", 32'(s_txData), 32'(S_FRAME));
    @(negedge clk);
    s_done = 1'b1; s_ack = 1'b1;
    d = cyc;
    @(negedge clk);
    s_done = 1'b0; s_ack = 1'b0;
    chk("s_ready_early", 32'(s_ready), 0);
    @(negedge clk);
    chk("s_ready_cycle", cyc - d, 2);
    chk("s_ack_ready", 32'(s_ready), 1);
    chk("s_ack_acknum", 32'(s_ackNum), 1);
    chk("s_ack_error", 32'(s_error), 0);
    chk("s_ack_busy", 32'(s_busy), 0);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst0_txdata", 32'(txData), 0);
    chk("rst0_txreq", 32'(txReq), 0);
    chk("rst0_busy", 32'(busy), 0);
    chk("rst0_ready", 32'(ready), 0);
    chk("rst0_error", 32'(error), 0);
    chk("rst0_acknum", 32'(ackNum), 0);

    // Auto-start after reset, master always acks.
    for (int i = 0; i < NREG; i++) nack_plan[i] = 0;
    run_seq(1'b0, 1'b0);
    // Re-run from DONE with entry 2 NACKed once.
    for (int i = 0; i < NREG; i++) nack_plan[i] = 0;
    nack_plan[2] = 1;
    run_seq(1'b1, 1'b0);
    // Entry 3 exhausts all attempts.
    for (int i = 0; i < NREG; i++) nack_plan[i] = 0;
    nack_plan[3] = 3;
    run_seq(1'b1, 1'b0);
    // Restart from FAIL with spurious pulses in GAP/LOAD.
    rand_plan();
    run_seq(1'b1, 1'b1);
    // Reset while waiting for the master, then auto-start again.
    reset_mid();
    // Randomised runs.
    for (int r = 0; r < 6; r++) begin
      rand_plan();
      run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    small_test();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
